// File: rtl/fixed_point_pkg.sv
// Shared Q5.11 fixed-point definitions for the divider and multiplier datapaths.
// Contents: format constants, the Q5.11 value type, the divider FSM state type,
// and the common Q_ONE / Q_MAX constants.
package fixed_point_pkg;

  localparam int unsigned Q_WIDTH = 16;
  localparam int unsigned Q_FRAC  = 11;

  typedef logic [Q_WIDTH-1:0] q5_11_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam q5_11_t Q_ONE = 16'h0800;
  localparam q5_11_t Q_MAX = 16'hFFFF;

endpackage

// File: rtl/fixed_divider_if.sv
// Handshake bundle for the fixed-point divider.
// Input side : in_valid, in_ready, dividend, divisor.
// Output side: out_valid, out_ready, result, overflow, div_by_zero.
// master: the client issuing operands and consuming results.
// slave : the divider itself.
interface fixed_divider_if
  import fixed_point_pkg::*;
#(
  parameter int unsigned WIDTH = Q_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, result, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, result, overflow, div_by_zero
  );
endinterface

// File: rtl/fxdiv_step.sv
// One restoring-division step (combinational).
// Ports:
//   i_rem     : current partial remainder (WIDTH+1 bits)
//   i_bit     : next dividend bit shifted into the remainder
//   i_divisor : divisor
//   o_rem     : partial remainder after this step
//   o_qbit    : quotient bit produced by this step
module fxdiv_step
  import fixed_point_pkg::*;
#(
  parameter int unsigned WIDTH = Q_WIDTH
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_diff;

  assign w_shift = {i_rem, i_bit};
  // The remainder entering a step is always below the divisor, so the
  // difference fits in WIDTH+1 bits whenever it is taken.
  assign w_diff  = w_shift[WIDTH:0] - {1'b0, i_divisor};
  assign o_qbit  = (w_shift >= {2'b00, i_divisor});
  assign o_rem   = o_qbit ? w_diff : w_shift[WIDTH:0];

endmodule

// File: rtl/fixed_divider.sv
// Iterative unsigned Q5.11 divider: result = (dividend << FRAC) / divisor.
// Restoring division, one quotient bit per clock, valid/ready on both sides.
// Optional macro FIXED_DIVIDER_ROUND_EN adds a guard bit and rounds half up
// (one extra iteration); without it the quotient is truncated.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : fixed_divider_if slave (operands in, result/flags out)
module fixed_divider
  import fixed_point_pkg::*;
#(
  parameter int unsigned WIDTH = Q_WIDTH,
  parameter int unsigned FRAC  = Q_FRAC
) (
  input  logic           clk,
  input  logic           rst_n,
  fixed_divider_if.slave bus
);

  localparam int unsigned ITER   = WIDTH + FRAC;
`ifdef FIXED_DIVIDER_ROUND_EN
  localparam int unsigned N_ITER = ITER + 1;
`else
  localparam int unsigned N_ITER = ITER;
`endif
  localparam int unsigned CNT_W  = $clog2(N_ITER + 1);

  div_state_e        r_state;
  logic [WIDTH-1:0]  r_divisor;
  logic [N_ITER-1:0] r_dvd;
  logic [WIDTH:0]    r_rem;
  // Holds all but the final quotient bit; the last bit is merged in
  // combinationally on the final step.
  logic [N_ITER-2:0] r_quo;
  logic [CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_result;
  logic              r_overflow;
  logic              r_dbz;

  logic [WIDTH:0]    w_rem_next;
  logic              w_qbit;
  logic [N_ITER-1:0] w_quo_next;
  logic              w_sat;
  logic [WIDTH-1:0]  w_final;
  logic              w_last;

  fxdiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[N_ITER-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  assign w_quo_next = {r_quo, w_qbit};
  assign w_last     = (r_cnt == CNT_W'(N_ITER - 1));

`ifdef FIXED_DIVIDER_ROUND_EN
  logic [ITER-1:0] w_trunc;
  logic [WIDTH:0]  w_sum;

  // LSB of the extended quotient is the guard bit; adding it rounds half up.
  assign w_trunc = w_quo_next[N_ITER-1:1];
  assign w_sum   = {1'b0, w_trunc[WIDTH-1:0]} + {{WIDTH{1'b0}}, w_quo_next[0]};
  assign w_sat   = (|w_trunc[ITER-1:WIDTH]) | w_sum[WIDTH];
  assign w_final = w_sum[WIDTH-1:0];
`else
  assign w_sat   = |w_quo_next[ITER-1:WIDTH];
  assign w_final = w_quo_next[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_divisor  <= '0;
      r_dvd      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.divisor == '0) begin
              r_result   <= '1;
              r_overflow <= 1'b0;
              r_dbz      <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_divisor  <= bus.divisor;
              r_dvd      <= {bus.dividend, {(N_ITER - WIDTH){1'b0}}};
              r_rem      <= '0;
              r_quo      <= '0;
              r_cnt      <= '0;
              r_overflow <= 1'b0;
              r_dbz      <= 1'b0;
              r_state    <= BUSY;
            end
          end
        end
        BUSY: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next[N_ITER-2:0];
          r_dvd <= r_dvd << 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_result   <= w_sat ? '1 : w_final;
            r_overflow <= w_sat;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = (r_state == DONE);
  assign bus.result      = r_result;
  assign bus.overflow    = r_overflow;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_fixed_divider.sv
module tb_fixed_divider;

`ifdef FIXED_DIVIDER_ROUND_EN
  localparam int LAT = 28;
`else
  localparam int LAT = 27;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fixed_divider_if #(.WIDTH(16)) bus ();

  fixed_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact rational quotient from wide integer arithmetic.
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic ovf, output logic dbz);
    longint unsigned n;
    longint unsigned q;
    n = longint'(a);
    if (b == 16'h0) begin
      res = 16'hFFFF; ovf = 1'b0; dbz = 1'b1;
    end else begin
`ifdef FIXED_DIVIDER_ROUND_EN
      q = (((n << 12) / longint'(b)) + 1) >> 1;
`else
      q = (n << 11) / longint'(b);
`endif
      dbz = 1'b0;
      if (q > 64'hFFFF) begin
        res = 16'hFFFF; ovf = 1'b1;
      end else begin
        res = q[15:0]; ovf = 1'b0;
      end
    end
  endtask

  // Called at #1 after a rising edge with the DUT idle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                        input string tag);
    logic [15:0] e_res;
    logic        e_ovf;
    logic        e_dbz;
    int          lat;
    model(a, b, e_res, e_ovf, e_dbz);
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    // Keep in_valid high with different operands: must be ignored until idle.
    bus.dividend = a ^ 16'h5A5A;
    bus.divisor  = b + 16'd1;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), (b == 16'h0) ? 32'd0 : 32'(LAT));
    check({tag, ".result"}, 32'(bus.result), 32'(e_res));
    check({tag, ".overflow"}, 32'(bus.overflow), 32'(e_ovf));
    check({tag, ".div_by_zero"}, 32'(bus.div_by_zero), 32'(e_dbz));
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      check({tag, ".held_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ".held_result"}, 32'(bus.result), 32'(e_res));
      check({tag, ".held_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    // in_valid was high on the handoff edge; it must not have started an op.
    check({tag, ".post_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".post_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    logic [15:0] ra;
    logic [15:0] rb;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.result", 32'(bus.result), 32'd0);
    check("rst.overflow", 32'(bus.overflow), 32'd0);
    check("rst.div_by_zero", 32'(bus.div_by_zero), 32'd0);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(16'h1800, 16'h0C00, 0, "three_by_1p5");
    run_op(16'h0800, 16'h1800, 0, "one_by_three");
    run_op(16'h0800, 16'h0000, 0, "div_zero");
    run_op(16'hF800, 16'h0001, 0, "overflow");
    run_op(16'h1000, 16'h0800, 5, "backpressure");
    run_op(16'h0000, 16'h1234, 0, "zero_dividend");
    run_op(16'hFFFF, 16'hFFFF, 0, "max_by_max");

    // Abort in BUSY: no result may ever appear for it.
    bus.in_valid = 1'b1;
    bus.dividend = 16'h1800;
    bus.divisor  = 16'h0C00;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort.out_valid", 32'(bus.out_valid), 32'd0);
    check("abort.result", 32'(bus.result), 32'd0);
    check("abort.in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("abort.no_result", 32'(seen), 32'd0);

    run_op(16'h0800, 16'h0800, 2, "after_abort");

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'($urandom_range(0, 15));
        1:       rb = 16'($urandom_range(16'h0400, 16'h1000));
        default: rb = 16'($urandom);
      endcase
      run_op(ra, rb, int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
